// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and defaults for the register-file writeback port arbiter.
package wb_port_arbiter_pkg;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_REG_AW = 4;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_LD,
    WB_Q,
    WB_BYP
  } wb_src_e;

endpackage

// File: rtl/wb_port_arbiter_fifo.sv
// Small FIFO of pending ALU register writes ({rd, data}) with synchronous clear.
module wb_fifo #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic                         push,
  input  logic [REG_AW-1:0]            push_rd,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  output logic [REG_AW-1:0]            head_rd,
  output logic [DATA_W-1:0]            head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [REG_AW-1:0] rd_mem_q   [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the caller never pushes while full.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      rd_mem_q[wr_ptr_q]   <= push_rd;
      data_mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head_rd   = rd_mem_q[rd_ptr_q];
  assign head_data = data_mem_q[rd_ptr_q];
  assign count     = count_q;
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between load returns and ALU results.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = WB_DATA_W,
  parameter int unsigned REG_AW = WB_REG_AW,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         alu_valid,
  input  logic                         alu_nowrite,
  input  logic                         cond_pass,
  input  logic [REG_AW-1:0]            alu_rd,
  input  logic [DATA_W-1:0]            alu_data,
  output logic                         alu_ready,
  input  logic                         ld_valid,
  input  logic [REG_AW-1:0]            ld_rd,
  input  logic [DATA_W-1:0]            ld_data,
  input  logic                         flush,
  output logic                         rf_we,
  output logic [REG_AW-1:0]            rf_waddr,
  output logic [DATA_W-1:0]            rf_wdata,
  output logic                         wb_collide,
  output logic [$clog2(DEPTH+1)-1:0]   q_count
);

  wb_src_e           grant;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [REG_AW-1:0] head_rd;
  logic [DATA_W-1:0] head_data;
  logic              alu_qual, head_ok;

  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              collide_q, collide_d;

  assign alu_ready = !fifo_full;
  assign alu_qual  = alu_valid && alu_ready && cond_pass && !alu_nowrite && !flush;
  assign head_ok   = !fifo_empty && !flush;

  always_comb begin
    grant = WB_NONE;
    if (ld_valid)      grant = WB_LD;
    else if (head_ok)  grant = WB_Q;
    else if (alu_qual) grant = WB_BYP;
  end

  // A qualified entry that loses arbitration is queued; alu_ready already excludes the full case.
  assign fifo_pop  = (grant == WB_Q);
  assign fifo_push = alu_qual && (grant != WB_BYP);

  wb_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (flush),
    .push      (fifo_push),
    .push_rd   (alu_rd),
    .push_data (alu_data),
    .pop       (fifo_pop),
    .head_rd   (head_rd),
    .head_data (head_data),
    .count     (q_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    rf_we_d    = 1'b1;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    unique case (grant)
      WB_LD: begin
        rf_waddr_d = ld_rd;
        rf_wdata_d = ld_data;
      end
      WB_Q: begin
        rf_waddr_d = head_rd;
        rf_wdata_d = head_data;
      end
      WB_BYP: begin
        rf_waddr_d = alu_rd;
        rf_wdata_d = alu_data;
      end
      default: rf_we_d = 1'b0;
    endcase
  end

  assign collide_d = ld_valid &&
                     ((head_ok && (head_rd == ld_rd)) || (alu_qual && (alu_rd == ld_rd)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      collide_q  <= 1'b0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      collide_q  <= collide_d;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign wb_collide = collide_q;

endmodule
